// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes simpleRISC memory commands onto a 256-word synchronous
// RAM and a small I/O window (LED, HEX, switches, cycle counter), returning
// read data with a single-cycle ready pulse one cycle after acceptance.
module mem_io_bridge #(
    parameter int         DATA_W   = 16,
    parameter logic [8:0] LED_ADDR = 9'h100,
    parameter logic [8:0] HEX_ADDR = 9'h120,
    parameter logic [8:0] SW_ADDR  = 9'h140,
    parameter logic [8:0] CNT_ADDR = 9'h180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [8:0]        mem_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_ready,
    output logic [7:0]        ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [7:0]        sw_in,
    output logic [7:0]        ledr_out,
    output logic [15:0]       hex_out
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_ready;
    logic                w_cmd_valid;
    logic                w_is_wr;
    logic                w_io;
    logic                w_cnt_clr;
    logic [DATA_W-1:0]   w_io_rdata;

    logic                r_rd;
    logic                r_rd_io;
    logic [7:0]          r_ram_addr;
    logic [DATA_W-1:0]   r_io_rdata;
    logic [7:0]          r_sw_meta;
    logic [7:0]          r_sw_sync;
    logic [7:0]          r_led;
    logic [15:0]         r_hex;
    logic [15:0]         r_cnt;

    assign w_cmd_valid = (mem_cmd == 2'b01) || (mem_cmd == 2'b10);
    assign w_is_wr     = (mem_cmd == 2'b10);
    assign w_io        = mem_addr[8];
    assign w_cnt_clr   = w_accept && w_is_wr && (mem_addr == CNT_ADDR);

    // FSM state register; reset always returns to IDLE, even mid-response
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state, accept strobe and ready pulse; reset masks both strobes
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!reset && w_cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP: begin
                w_ready = !reset;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // I/O read mux, captured into r_io_rdata at the accept edge
    always_comb begin
        w_io_rdata = '0;
        case (mem_addr)
            SW_ADDR:  w_io_rdata = DATA_W'(r_sw_sync);
            CNT_ADDR: w_io_rdata = DATA_W'(r_cnt);
            LED_ADDR: w_io_rdata = DATA_W'(r_led);
            HEX_ADDR: w_io_rdata = DATA_W'(r_hex);
            default:  w_io_rdata = '0;
        endcase
    end

    // Response data: RAM data arrives one cycle after the address, I/O data is registered
    always_comb begin
        cpu_rdata = '0;
        if (w_ready && r_rd) cpu_rdata = r_rd_io ? r_io_rdata : ram_rdata;
    end

    assign mem_ready = w_ready;
    assign ram_we    = w_accept && w_is_wr && !w_io;
    assign ram_addr  = w_accept ? mem_addr[7:0] : r_ram_addr;
    assign ram_wdata = cpu_wdata;
    assign ledr_out  = r_led;
    assign hex_out   = r_hex;

    // Two-flop switch synchroniser and free-running counter (clear beats increment)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_cnt     <= '0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
            r_cnt     <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
        end
    end

    // Per-transaction capture and I/O register writes at the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd       <= 1'b0;
            r_rd_io    <= 1'b0;
            r_ram_addr <= '0;
            r_io_rdata <= '0;
            r_led      <= '0;
            r_hex      <= '0;
        end else if (w_accept) begin
            r_ram_addr <= mem_addr[7:0];
            r_rd       <= !w_is_wr;
            r_rd_io    <= w_io;
            if (!w_is_wr) r_io_rdata <= w_io_rdata;
            if (w_is_wr && (mem_addr == LED_ADDR)) r_led <= cpu_wdata[7:0];
            if (w_is_wr && (mem_addr == HEX_ADDR)) r_hex <= cpu_wdata[15:0];
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Testbench for mem_io_bridge: directed scenarios plus a randomized run, all
// checked against a transaction-level model of RAM, I/O registers and counter.
module tb_mem_io_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        mem_ready;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [7:0]  sw_in;
    logic [7:0]  ledr_out;
    logic [15:0] hex_out;

    localparam logic [8:0] LED_A = 9'h100;
    localparam logic [8:0] HEX_A = 9'h120;
    localparam logic [8:0] SW_A  = 9'h140;
    localparam logic [8:0] CNT_A = 9'h180;

    mem_io_bridge #(.DATA_W(16)) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mem_ready(mem_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sw_in(sw_in), .ledr_out(ledr_out), .hex_out(hex_out)
    );

    always #5 clk = ~clk;

    // Synchronous RAM attached to the bridge
    logic [15:0] ram_mem [256] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Model state
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_zero = -1;
    int          last_rst = -1;
    logic [7:0]  sw_hist [4];
    logic [15:0] m_ram [256] = '{default: 16'h0000};
    logic [7:0]  m_led = '0;
    logic [15:0] m_hex = '0;
    logic [7:0]  m_last_addr = '0;
    logic        m_busy = 1'b0;
    logic        m_isrd = 1'b0;
    logic [15:0] m_rd = '0;

    // Observed (pre-edge) and expected values for the most recent step
    logic        o_ready, o_we, e_ready, e_we, e_chk_rd;
    logic [15:0] o_rdata, o_hex, e_rdata, e_hex;
    logic [7:0]  o_addr, o_led, e_addr, e_led;

    task automatic drive(input logic rst, input logic [1:0] cmd, input logic [8:0] a,
                         input logic [15:0] wd);
        reset = rst; mem_cmd = cmd; mem_addr = a; cpu_wdata = wd;
    endtask

    // Sample the current cycle, advance the model across one rising edge,
    // return at the following falling edge.
    task automatic step();
        logic        acc;
        logic [15:0] pre_cnt;
        logic [7:0]  sync;
        #1;
        acc = !reset && !m_busy && (mem_cmd == 2'b01 || mem_cmd == 2'b10);
        o_ready = mem_ready; o_rdata = cpu_rdata; o_we = ram_we; o_addr = ram_addr;
        o_led = ledr_out; o_hex = hex_out;
        e_ready  = m_busy && !reset;
        e_chk_rd = !e_ready || m_isrd;
        e_rdata  = e_ready ? m_rd : 16'h0000;
        e_we     = acc && (mem_cmd == 2'b10) && !mem_addr[8];
        e_addr   = acc ? mem_addr[7:0] : m_last_addr;
        e_led    = m_led;
        e_hex    = m_hex;
        sw_hist[cyc % 4] = sw_in;
        pre_cnt = 16'(cyc - last_zero - 1);
        sync    = (cyc - 2 > last_rst) ? sw_hist[(cyc - 2) % 4] : 8'h00;
        if (acc) begin
            m_last_addr = mem_addr[7:0];
            m_isrd      = (mem_cmd == 2'b01);
            if (m_isrd) begin
                if (!mem_addr[8])            m_rd = m_ram[mem_addr[7:0]];
                else if (mem_addr == SW_A)   m_rd = {8'h00, sync};
                else if (mem_addr == CNT_A)  m_rd = pre_cnt;
                else if (mem_addr == LED_A)  m_rd = {8'h00, m_led};
                else if (mem_addr == HEX_A)  m_rd = m_hex;
                else                         m_rd = 16'h0000;
            end else begin
                if (!mem_addr[8])            m_ram[mem_addr[7:0]] = cpu_wdata;
                else if (mem_addr == LED_A)  m_led = cpu_wdata[7:0];
                else if (mem_addr == HEX_A)  m_hex = cpu_wdata;
                else if (mem_addr == CNT_A)  last_zero = cyc;
            end
        end
        if (reset) begin
            m_led = '0; m_hex = '0; m_last_addr = '0; m_isrd = 1'b0;
            last_zero = cyc; last_rst = cyc;
        end
        m_busy = acc;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 2'b00, 9'h000, 16'h0000);
        sw_in = 8'h00;
        repeat (3) step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000);
        step();
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", o_ready); end
        total++; if (o_rdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", o_rdata); end
        total++; if (o_we !== 1'b0 || o_addr !== 8'h00) begin bad++; $display("FAIL rst_ram got we=%0b addr=%h exp 0/00", o_we, o_addr); end
        total++; if (o_led !== 8'h00 || o_hex !== 16'h0000) begin bad++; $display("FAIL rst_io got led=%h hex=%h exp 00/0000", o_led, o_hex); end
        drive(1'b0, 2'b01, CNT_A, 16'h0000);
        step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000);
        step();
        total++; if (o_ready !== 1'b1 || o_rdata !== e_rdata || o_rdata !== 16'h0001) begin bad++; $display("FAIL rst_cnt got rdy=%0b data=%h exp 1/%h", o_ready, o_rdata, e_rdata); end
    endtask

    task automatic test_ram();
        drive(1'b0, 2'b10, 9'h005, 16'hABCD);
        step();
        total++; if (o_we !== 1'b1 || o_addr !== 8'h05 || o_ready !== 1'b0) begin bad++; $display("FAIL ram_wr_accept got we=%0b addr=%h rdy=%0b exp 1/05/0", o_we, o_addr, o_ready); end
        drive(1'b0, 2'b10, 9'h005, 16'h1111);
        step();
        total++; if (o_ready !== 1'b1 || o_we !== 1'b0) begin bad++; $display("FAIL ram_wr_resp got rdy=%0b we=%0b exp 1/0", o_ready, o_we); end
        drive(1'b0, 2'b01, 9'h005, 16'h0000);
        step();
        total++; if (o_we !== 1'b0 || o_ready !== 1'b0 || o_addr !== 8'h05) begin bad++; $display("FAIL ram_rd_accept got we=%0b rdy=%0b addr=%h exp 0/0/05", o_we, o_ready, o_addr); end
        drive(1'b0, 2'b00, 9'h000, 16'h0000);
        step();
        total++; if (o_ready !== 1'b1 || o_rdata !== 16'hABCD || o_rdata !== e_rdata) begin bad++; $display("FAIL ram_rd got rdy=%0b data=%h exp 1/ABCD", o_ready, o_rdata); end
        step();
        total++; if (o_addr !== 8'h05 || o_ready !== 1'b0) begin bad++; $display("FAIL ram_addr_hold got addr=%h rdy=%0b exp 05/0", o_addr, o_ready); end
    endtask

    task automatic test_switch();
        sw_in = 8'h5A;
        drive(1'b0, 2'b00, 9'h000, 16'h0000);
        repeat (3) step();
        drive(1'b0, 2'b01, SW_A, 16'h0000);
        step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000);
        step();
        total++; if (o_rdata !== 16'h005A || o_rdata !== e_rdata) begin bad++; $display("FAIL sw_read got=%h exp=005A", o_rdata); end
        sw_in = 8'hA5;
        drive(1'b0, 2'b01, SW_A, 16'h0000);
        step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000);
        step();
        total++; if (o_rdata !== 16'h005A || o_rdata !== e_rdata) begin bad++; $display("FAIL sw_latency got=%h exp=005A", o_rdata); end
        repeat (2) step();
        drive(1'b0, 2'b01, SW_A, 16'h0000);
        step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000);
        step();
        total++; if (o_rdata !== 16'h00A5) begin bad++; $display("FAIL sw_new got=%h exp=00A5", o_rdata); end
    endtask

    task automatic test_io_regs();
        drive(1'b0, 2'b10, HEX_A, 16'h1234); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_hex !== 16'h1234 || o_ready !== 1'b1) begin bad++; $display("FAIL hex_wr got hex=%h rdy=%0b exp 1234/1", o_hex, o_ready); end
        drive(1'b0, 2'b10, LED_A, 16'h00FF); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_led !== 8'hFF) begin bad++; $display("FAIL led_wr got=%h exp=FF", o_led); end
        drive(1'b0, 2'b10, SW_A, 16'hBEEF); step();
        total++; if (o_we !== 1'b0) begin bad++; $display("FAIL sw_wr_we got=%0b exp=0", o_we); end
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_ready !== 1'b1 || o_led !== 8'hFF || o_hex !== 16'h1234) begin bad++; $display("FAIL sw_wr got rdy=%0b led=%h hex=%h exp 1/FF/1234", o_ready, o_led, o_hex); end
        drive(1'b0, 2'b10, 9'h1F0, 16'hFFFF); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_ready !== 1'b1 || o_led !== 8'hFF || o_hex !== 16'h1234) begin bad++; $display("FAIL unmapped_wr got rdy=%0b led=%h hex=%h exp 1/FF/1234", o_ready, o_led, o_hex); end
        drive(1'b0, 2'b01, 9'h1F0, 16'h0000); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_ready !== 1'b1 || o_rdata !== 16'h0000) begin bad++; $display("FAIL unmapped_rd got rdy=%0b data=%h exp 1/0000", o_ready, o_rdata); end
        drive(1'b0, 2'b01, HEX_A, 16'h0000); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_rdata !== 16'h1234) begin bad++; $display("FAIL hex_rd got=%h exp=1234", o_rdata); end
        drive(1'b0, 2'b01, LED_A, 16'h0000); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_rdata !== 16'h00FF) begin bad++; $display("FAIL led_rd got=%h exp=00FF", o_rdata); end
    endtask

    task automatic test_counter();
        int n;
        int z;
        n = $urandom_range(3, 20);
        drive(1'b0, 2'b10, CNT_A, 16'h0000); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        repeat (n) step();
        drive(1'b0, 2'b01, CNT_A, 16'h0000); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_rdata !== 16'(n + 1) || o_rdata !== e_rdata) begin bad++; $display("FAIL cnt_clear n=%0d got=%h exp=%h", n, o_rdata, 16'(n + 1)); end
        z = cyc;
        drive(1'b0, 2'b10, CNT_A, 16'h0000); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000);
        while (cyc < z + 65537) step();
        drive(1'b0, 2'b01, CNT_A, 16'h0000); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_rdata !== 16'h0000 || o_ready !== 1'b1) begin bad++; $display("FAIL cnt_wrap got rdy=%0b data=%h exp 1/0000", o_ready, o_rdata); end
    endtask

    task automatic test_reset_cases();
        drive(1'b1, 2'b10, LED_A, 16'h00AA); step();
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rst_acc_ready got=%0b exp=0", o_ready); end
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_ready !== 1'b0 || o_led !== 8'h00) begin bad++; $display("FAIL rst_acc_led got rdy=%0b led=%h exp 0/00", o_ready, o_led); end
        drive(1'b1, 2'b10, 9'h007, 16'h7777); step();
        total++; if (o_we !== 1'b0) begin bad++; $display("FAIL rst_acc_we got=%0b exp=0", o_we); end
        drive(1'b0, 2'b01, 9'h007, 16'h0000); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_ready !== 1'b1 || o_rdata !== 16'h0000) begin bad++; $display("FAIL rst_ram_untouched got rdy=%0b data=%h exp 1/0000", o_ready, o_rdata); end
        drive(1'b0, 2'b10, HEX_A, 16'h4321); step();
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        drive(1'b0, 2'b01, HEX_A, 16'h0000); step();
        drive(1'b1, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_ready !== 1'b0 || o_rdata !== 16'h0000) begin bad++; $display("FAIL rst_resp got rdy=%0b data=%h exp 0/0000", o_ready, o_rdata); end
        drive(1'b0, 2'b10, 9'h009, 16'h9999); step();
        total++; if (o_ready !== 1'b0 || o_we !== 1'b1) begin bad++; $display("FAIL rst_resp_idle got rdy=%0b we=%0b exp 0/1", o_ready, o_we); end
        drive(1'b0, 2'b00, 9'h000, 16'h0000); step();
        total++; if (o_ready !== 1'b1 || o_hex !== 16'h0000) begin bad++; $display("FAIL rst_resp_next got rdy=%0b hex=%h exp 1/0000", o_ready, o_hex); end
    endtask

    task automatic test_random();
        logic [8:0] a;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = {6'b000000, 3'($urandom_range(0, 7))};
                4:          a = LED_A;
                5:          a = HEX_A;
                6:          a = SW_A;
                7:          a = CNT_A;
                8:          a = 9'h1F0;
                default:    a = {1'b1, 8'($urandom)};
            endcase
            sw_in = 8'($urandom);
            drive(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)), a, 16'($urandom));
            step();
            total++; if (o_ready !== e_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%0b exp=%0b", cyc, o_ready, e_ready); end
            if (e_chk_rd) begin
                total++; if (o_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, o_rdata, e_rdata); end
            end
            total++; if (o_we !== e_we || o_addr !== e_addr) begin bad++; $display("FAIL rnd_ram cyc=%0d got we=%0b addr=%h exp %0b/%h", cyc, o_we, o_addr, e_we, e_addr); end
            total++; if (o_led !== e_led || o_hex !== e_hex) begin bad++; $display("FAIL rnd_io cyc=%0d got led=%h hex=%h exp %h/%h", cyc, o_led, o_hex, e_led, e_hex); end
        end
    endtask

    initial begin
        drive(1'b1, 2'b00, 9'h000, 16'h0000);
        sw_in = 8'h00;
        @(negedge clk);
        test_reset();
        test_ram();
        test_switch();
        test_io_regs();
        test_counter();
        test_reset_cases();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
